tiny_dnn_unpool: RTL and testbench

//  Backward (gradient) path of 2x2/stride-2 max pooling. Consumes one upstream gradient per pooled

---
 rtl/tiny_dnn_pool_pkg.sv | 26 ++
 rtl/tiny_dnn_pool_addr.sv | 46 ++++
 rtl/tiny_dnn_unpool.sv | 123 ++++++++++++
 tb/tb_tiny_dnn_unpool.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tiny_dnn_pool_pkg.sv
// ---------------------------------------------------------------------------
// tiny_dnn_pool_pkg : widths and lane encoding shared by the pool/unpool blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tiny_dnn_pool_pkg;
  localparam int DW   = 16;
  localparam int IDXW = 16;
  localparam int OWW  = 5;
  localparam int AW   = IDXW - 1;

  // Lane code is {col,row}; matches the forward pool's argmax encoding.
  typedef enum logic [1:0] {
    L_R0C0 = 2'd0,
    L_R1C0 = 2'd1,
    L_R0C1 = 2'd2,
    L_R1C1 = 2'd3
  } lane_e;

  function automatic lane_e lane_of(input logic row, input logic col);
    return lane_e'({col, row});
  endfunction
endpackage

`default_nettype wire

// File: rtl/tiny_dnn_pool_addr.sv
// ---------------------------------------------------------------------------
// tiny_dnn_pool_addr : raster window-base counter (pa) for 2x2/stride-2 pooling
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tiny_dnn_pool_addr
  import tiny_dnn_pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [OWW-1:0]    ow,
  output logic [AW-1:0]     pa
);

  logic [OWW-1:0] px;
  logic           row_end;
  logic [AW-1:0]  ow_ext;

  // 6-bit compare so ow=0 can never match and the row jump is never taken.
  assign row_end = ({1'b0, px} + {{OWW{1'b0}}, 1'b1}) == {1'b0, ow};
  assign ow_ext  = {{(AW-OWW){1'b0}}, ow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa <= '0;
      px <= '0;
    end else if (clr) begin
      pa <= '0;
      px <= '0;
    end else if (en) begin
      if (row_end) begin
        pa <= pa + ow_ext + {{(AW-1){1'b0}}, 1'b1};
        px <= '0;
      end else begin
        pa <= pa + {{(AW-1){1'b0}}, 1'b1};
        px <= px + {{(OWW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tiny_dnn_unpool.sv
// ---------------------------------------------------------------------------
// tiny_dnn_unpool : max-pool backward path, routes gradient to the argmax lane
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tiny_dnn_unpool
  import tiny_dnn_pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              unpool,
  input  logic              u_fin,
  input  logic              en,
  input  logic [OWW-1:0]    ow,
  input  logic [DW-1:0]     gi,
  input  logic [IDXW-1:0]   pi,
  output logic [DW-1:0]     d0,
  output logic [DW-1:0]     d1,
  output logic [DW-1:0]     d2,
  output logic [DW-1:0]     d3,
  output logic              dv,
  output logic              unpool_busy,
  output logic              idx_err
);

  logic [AW-1:0]   pa;
  logic            s1_v;
  logic [DW-1:0]   s1_gi;
  logic [IDXW-1:0] s1_pi;
  logic [AW-1:0]   s1_pa;
  logic            s2_v;
  logic [DW-1:0]   s2_gi;
  lane_e           s2_lane;
  logic            s2_hit;
  logic [AW-1:0]   row1_base;
  logic            row;
  logic            hit;
  logic [DW-1:0]   d_q [4];

  tiny_dnn_pool_addr u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~unpool | u_fin),
    .en    (en),
    .ow    (ow),
    .pa    (pa)
  );

  // S1: capture sample with the pre-update window base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_gi <= '0;
      s1_pi <= '0;
      s1_pa <= '0;
    end else begin
      s1_v <= unpool & en;
      if (unpool && en) begin
        s1_gi <= gi;
        s1_pi <= pi;
        s1_pa <= pa;
      end
    end
  end

  // Second window row starts ow bases later; modulo-2^15 wrap is intended.
  assign row1_base = s1_pa + {{(AW-OWW){1'b0}}, ow};
  assign row       = (s1_pi[IDXW-1:1] == row1_base);
  assign hit       = row | (s1_pi[IDXW-1:1] == s1_pa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_gi   <= '0;
      s2_lane <= L_R0C0;
      s2_hit  <= 1'b0;
    end else begin
      s2_v <= unpool & s1_v;
      if (unpool && s1_v) begin
        s2_gi   <= s1_gi;
        s2_lane <= lane_of(row, s1_pi[0]);
        s2_hit  <= hit;
      end
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q[i] <= '0;
        end else if (unpool && s2_v) begin
          d_q[i] <= (s2_hit && (s2_lane == lane_e'(i))) ? s2_gi : '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv      <= 1'b0;
      idx_err <= 1'b0;
    end else if (!unpool) begin
      dv      <= 1'b0;
      idx_err <= 1'b0;
    end else begin
      dv <= s2_v;
      if (s2_v && !s2_hit) begin
        idx_err <= 1'b1;
      end
    end
  end

  assign d0          = d_q[0];
  assign d1          = d_q[1];
  assign d2          = d_q[2];
  assign d3          = d_q[3];
  assign unpool_busy = s1_v | s2_v;

endmodule

`default_nettype wire

// File: tb/tb_tiny_dnn_unpool.sv
// ---------------------------------------------------------------------------
// tb_tiny_dnn_unpool : randomized bench with a latency-queue reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tiny_dnn_unpool;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        unpool = 1'b1;
  logic        u_fin = 1'b0;
  logic        en = 1'b0;
  logic [4:0]  ow = 5'd4;
  logic [15:0] gi = '0;
  logic [15:0] pi = '0;
  logic [15:0] d0, d1, d2, d3;
  logic        dv, unpool_busy, idx_err;

  tiny_dnn_unpool dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .unpool      (unpool),
    .u_fin       (u_fin),
    .en          (en),
    .ow          (ow),
    .gi          (gi),
    .pi          (pi),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .dv          (dv),
    .unpool_busy (unpool_busy),
    .idx_err     (idx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          lane;   // -1 = index did not match the window
    logic [15:0] g;
  } ent_t;

  ent_t        q[$];
  int          k = 0;
  int          m_pa = 0;
  int          m_px = 0;
  logic        exp_dv = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_d [4] = '{default: 16'h0};
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, k);
  endtask

  task automatic check_all();
    check("dv", {31'd0, dv}, {31'd0, exp_dv});
    check("d0", {16'd0, d0}, {16'd0, exp_d[0]});
    check("d1", {16'd0, d1}, {16'd0, exp_d[1]});
    check("d2", {16'd0, d2}, {16'd0, exp_d[2]});
    check("d3", {16'd0, d3}, {16'd0, exp_d[3]});
    check("idx_err", {31'd0, idx_err}, {31'd0, exp_err});
    check("busy", {31'd0, unpool_busy}, {31'd0, logic'(q.size() != 0)});
  endtask

  task automatic model_reset();
    q.delete();
    m_pa = 0;
    m_px = 0;
    exp_dv = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) exp_d[i] = 16'h0;
  endtask

  // One clock: check state left by the last edge, then drive and predict the next edge.
  task automatic step(input logic e, input logic [15:0] g, input logic [15:0] p,
                      input logic up, input logic uf, input logic [4:0] o);
    ent_t t;
    int   base;
    int   second_row;
    @(negedge clk);
    check_all();
    en = e; gi = g; pi = p; unpool = up; u_fin = uf; ow = o;
    k++;
    if (!up) begin
      q.delete();
      m_pa = 0;
      m_px = 0;
      exp_err = 1'b0;
      exp_dv = 1'b0;
    end else begin
      if (e) begin
        base       = int'(p[15:1]);
        second_row = (m_pa + int'(o)) % 32768;
        t.due = k + 2;
        t.g   = g;
        if (base == second_row)  t.lane = 2 * int'(p[0]) + 1;
        else if (base == m_pa)   t.lane = 2 * int'(p[0]);
        else                     t.lane = -1;
        q.push_back(t);
      end
      if (uf) begin
        m_pa = 0;
        m_px = 0;
      end else if (e) begin
        if (m_px + 1 == int'(o)) begin
          m_pa = (m_pa + 1 + int'(o)) % 32768;
          m_px = 0;
        end else begin
          m_pa = (m_pa + 1) % 32768;
          m_px = (m_px + 1) % 32;
        end
      end
      exp_dv = 1'b0;
      if (q.size() != 0 && q[0].due == k) begin
        t = q.pop_front();
        exp_dv = 1'b1;
        for (int i = 0; i < 4; i++) exp_d[i] = (i == t.lane) ? t.g : 16'h0;
        if (t.lane < 0) exp_err = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, ow);
  endtask

  task automatic async_reset();
    @(negedge clk);
    check_all();
    #2 rst_n = 1'b0;
    en = 1'b0; unpool = 1'b1; u_fin = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] pick_pi(input logic [4:0] o);
    int r;
    int base;
    r = $urandom_range(0, 9);
    if (r < 5)      base = m_pa;
    else if (r < 9) base = (m_pa + int'(o)) % 32768;
    else            base = $urandom_range(0, 32767);
    return {base[14:0], 1'($urandom_range(0, 1))};
  endfunction

  initial begin
    logic [4:0] o;
    logic       e, uf, up;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // ow=4, base 0: column-1 winner in row 0
    step(1'b1, 16'h3F80, {15'd0, 1'b1}, 1'b1, 1'b0, 5'd4);
    idle(3);
    // restart at base 0, then row-1 winners for both columns
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd4);
    step(1'b1, 16'h8000, {15'd4, 1'b0}, 1'b1, 1'b0, 5'd4);
    step(1'b1, 16'h7FC1, {15'd5, 1'b1}, 1'b1, 1'b0, 5'd4);
    idle(3);
    // ow=2 back-to-back, bases 0,1,4
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd2);
    step(1'b1, 16'h1111, {15'd0, 1'b0}, 1'b1, 1'b0, 5'd2);
    step(1'b1, 16'h2222, {15'd3, 1'b1}, 1'b1, 1'b0, 5'd2);
    step(1'b1, 16'h3333, {15'd6, 1'b1}, 1'b1, 1'b0, 5'd2);
    idle(4);
    // bad index, then good samples: error stays sticky
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd4);
    step(1'b1, 16'h4444, {15'd9, 1'b0}, 1'b1, 1'b0, 5'd4);
    step(1'b1, 16'h5555, {15'd1, 1'b0}, 1'b1, 1'b0, 5'd4);
    idle(4);
    // flush with two samples in flight
    step(1'b1, 16'h6666, {15'd0, 1'b0}, 1'b1, 1'b0, 5'd4);
    step(1'b1, 16'h7777, {15'd1, 1'b0}, 1'b1, 1'b0, 5'd4);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd4);
    idle(3);
    // ow=0: both candidate rows coincide
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 16'hFFFF, {15'd0, 1'b1}, 1'b1, 1'b0, 5'd0);
    step(1'b1, 16'hABCD, {15'd1, 1'b0}, 1'b1, 1'b0, 5'd0);
    idle(3);
    // async reset mid-stream
    step(1'b1, 16'h1234, {15'd2, 1'b0}, 1'b1, 1'b0, 5'd0);
    step(1'b1, 16'h5678, {15'd9, 1'b0}, 1'b1, 1'b0, 5'd0);
    idle(2);
    async_reset();

    o = 5'd4;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      up = ($urandom_range(0, 99) >= 2);
      if (!up) o = 5'($urandom_range(0, 31));
      e  = ($urandom_range(0, 99) < 70);
      uf = ($urandom_range(0, 99) < 3);
      step(e, 16'($urandom), pick_pi(o), up, uf, o);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
